hazard_scoreboard: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Tracks in-flight register writers (E/M/W) as a

---
 rtl/hazard_scoreboard_pkg.sv | 37 +++
 rtl/hazard_scoreboard_fwd_sel.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and scoreboard entry type for the pipeline hazard controller.
package hazard_scoreboard_pkg;

  localparam logic [1:0] VALUE_USE_NOW  = 2'd0;
  localparam logic [1:0] VALUE_USE_NEXT = 2'd1;
  localparam logic [1:0] VALUE_USE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: 5'd0, tnew: 2'd0};

  // One pipeline step closer to the result: Tnew counts down and sticks at zero.
  function automatic sb_entry_t age_entry(input sb_entry_t ent);
    sb_entry_t aged;
    aged      = ent;
    aged.tnew = (ent.tnew == 2'd0) ? 2'd0 : (ent.tnew - 2'd1);
    return aged;
  endfunction

  function automatic logic entry_hit(input sb_entry_t ent, input logic [4:0] src);
    return ent.valid && (ent.dst != 5'd0) && (ent.dst == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Per-operand forwarding select and data-stall term; E_VARIANT ignores the E entry and Tuse.
module hz_fwd_sel
  import hazard_scoreboard_pkg::*;
#(
  parameter bit E_VARIANT = 1'b0
) (
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  sb_entry_t  e_ent,
  input  sb_entry_t  m_ent,
  input  sb_entry_t  w_ent,
  output logic [1:0] sel,
  output logic       stall_term
);

  logic live_s;
  logic e_hit_s;
  logic m_hit_s;
  logic w_hit_s;

  // Stage match qualification for this operand
  always_comb begin
    live_s  = E_VARIANT ? 1'b1 : (tuse != VALUE_USE_NONE);
    e_hit_s = !E_VARIANT && live_s && entry_hit(e_ent, src);
    m_hit_s = live_s && entry_hit(m_ent, src);
    w_hit_s = live_s && entry_hit(w_ent, src);
  end

  // Youngest match wins; a not-yet-ready youngest match hides older copies
  always_comb begin
    sel = FWD_RF;
    if (e_hit_s) begin
      sel = (e_ent.tnew == 2'd0) ? FWD_E : FWD_RF;
    end else if (m_hit_s) begin
      sel = (m_ent.tnew == 2'd0) ? FWD_M : FWD_RF;
    end else if (w_hit_s) begin
      sel = (w_ent.tnew == 2'd0) ? FWD_W : FWD_RF;
    end else begin
      sel = FWD_RF;
    end
  end

  // Result not produced in time for its use: only E and M can be late
  always_comb begin
    stall_term = 1'b0;
    if (E_VARIANT) begin
      stall_term = 1'b0;
    end else begin
      stall_term = (e_hit_s && (e_ent.tnew > tuse)) ||
                   (m_hit_s && (m_ent.tnew > tuse));
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: stall, D/E forwarding selects and mult/div busy sequencing.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_use,
  input  logic [1:0] d_rt_use,
  input  logic       d_wr,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  sb_entry_t  e_ent_r;
  sb_entry_t  m_ent_r;
  sb_entry_t  w_ent_r;
  logic [4:0] e_rs_r;
  logic [4:0] e_rt_r;
  logic [3:0] md_cnt_r;

  logic rs_stall_s;
  logic rt_stall_s;
  logic e_rs_stall_s;
  logic e_rt_stall_s;
  logic md_busy_s;
  logic md_stall_s;
  logic stall_s;

  hz_fwd_sel #(.E_VARIANT(1'b0)) u_sel_d_rs (
    .src(d_rs), .tuse(d_rs_use), .e_ent(e_ent_r), .m_ent(m_ent_r), .w_ent(w_ent_r),
    .sel(fwd_d_rs), .stall_term(rs_stall_s)
  );

  hz_fwd_sel #(.E_VARIANT(1'b0)) u_sel_d_rt (
    .src(d_rt), .tuse(d_rt_use), .e_ent(e_ent_r), .m_ent(m_ent_r), .w_ent(w_ent_r),
    .sel(fwd_d_rt), .stall_term(rt_stall_s)
  );

  hz_fwd_sel #(.E_VARIANT(1'b1)) u_sel_e_rs (
    .src(e_rs_r), .tuse(VALUE_USE_NOW), .e_ent(e_ent_r), .m_ent(m_ent_r), .w_ent(w_ent_r),
    .sel(fwd_e_rs), .stall_term(e_rs_stall_s)
  );

  hz_fwd_sel #(.E_VARIANT(1'b1)) u_sel_e_rt (
    .src(e_rt_r), .tuse(VALUE_USE_NOW), .e_ent(e_ent_r), .m_ent(m_ent_r), .w_ent(w_ent_r),
    .sel(fwd_e_rt), .stall_term(e_rt_stall_s)
  );

  // Stall combines data hazards with HI/LO access while the md unit is (or is becoming) busy
  always_comb begin
    md_busy_s  = (md_cnt_r != 4'd0);
    md_stall_s = d_md_use && (md_busy_s || e_md_start);
    stall_s    = rs_stall_s | rt_stall_s | e_rs_stall_s | e_rt_stall_s | md_stall_s;
  end

  assign stall   = stall_s;
  assign md_busy = md_busy_s;

  // Pipeline scoreboard advance and mult/div busy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ent_r  <= SB_EMPTY;
      m_ent_r  <= SB_EMPTY;
      w_ent_r  <= SB_EMPTY;
      e_rs_r   <= 5'd0;
      e_rt_r   <= 5'd0;
      md_cnt_r <= 4'd0;
    end else begin
      w_ent_r <= age_entry(m_ent_r);
      m_ent_r <= age_entry(e_ent_r);
      if (stall_s) begin
        e_ent_r <= SB_EMPTY;
        e_rs_r  <= 5'd0;
        e_rt_r  <= 5'd0;
      end else begin
        e_ent_r <= '{valid: d_wr && (d_dst != 5'd0), dst: d_dst, tnew: d_tnew};
        e_rs_r  <= d_rs;
        e_rt_r  <= d_rt;
      end
      if (e_md_start) begin
        md_cnt_r <= e_md_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_r != 4'd0) begin
        md_cnt_r <= md_cnt_r - 4'd1;
      end else begin
        md_cnt_r <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_use, d_rt_use, d_tnew;
  logic       d_wr, d_md_use, e_md_start, e_md_div;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_wr(d_wr), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .e_md_start(e_md_start), .e_md_div(e_md_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] drs, drt, ers, ert;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: the three in-flight instructions (0=E, 1=M, 2=W) as issued,
  // with remaining Tnew derived from how many stages each has advanced.
  typedef struct {
    bit wr;
    int dst;
    int tnew0;
    int rs;
    int rt;
  } instr_t;

  instr_t pipe[3];
  int     cyc = 0;
  int     md_last = -1;

  function automatic int remain(int s);
    return (pipe[s].tnew0 > s) ? (pipe[s].tnew0 - s) : 0;
  endfunction

  function automatic bit hits(int s, int src);
    return pipe[s].wr && (pipe[s].dst != 0) && (pipe[s].dst == src);
  endfunction

  function automatic int d_sel(int src, int use_v);
    if (use_v == 3) return 0;
    for (int s = 0; s < 3; s++)
      if (hits(s, src)) return (remain(s) == 0) ? (3 - s) : 0;
    return 0;
  endfunction

  function automatic bit d_stall(int src, int use_v);
    if (use_v == 3) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (hits(s, src) && remain(s) > use_v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int e_sel(int src);
    for (int s = 1; s < 3; s++)
      if (hits(s, src)) return (remain(s) == 0) ? (3 - s) : 0;
    return 0;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++) pipe[s] = '{wr: 1'b0, dst: 0, tnew0: 0, rs: 0, rt: 0};
    md_last = -1;
  endtask

  // One D-stage cycle: drive, predict, then let the edge happen and advance the model.
  task automatic step(input bit rst_low, input bit wr, input int dst, input int tnew,
                      input int rs, input int ru, input int rt, input int tu,
                      input bit mduse, input bit mds, input bit mddiv);
    exp_t   e;
    instr_t ni;
    bit     busy_now;
    rst_n      = !rst_low;
    d_wr       = wr;
    d_dst      = 5'(dst);
    d_tnew     = 2'(tnew);
    d_rs       = 5'(rs);
    d_rs_use   = 2'(ru);
    d_rt       = 5'(rt);
    d_rt_use   = 2'(tu);
    d_md_use   = mduse;
    e_md_start = mds;
    e_md_div   = mddiv;
    if (rst_low) clear_model();
    busy_now = (cyc <= md_last);
    e.stall  = d_stall(rs, ru) | d_stall(rt, tu) | (mduse && (busy_now || mds));
    e.drs    = 2'(d_sel(rs, ru));
    e.drt    = 2'(d_sel(rt, tu));
    e.ers    = 2'(e_sel(pipe[0].rs));
    e.ert    = 2'(e_sel(pipe[0].rt));
    e.busy   = busy_now;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_low) begin
      if (mds) md_last = cyc + (mddiv ? DIV_N : MULT_N);
      ni = '{wr: wr, dst: dst, tnew0: tnew, rs: rs, rt: rt};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e.stall) pipe[0] = '{wr: 1'b0, dst: 0, tnew0: 0, rs: 0, rt: 0};
      else         pipe[0] = ni;
    end
    cyc++;
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 0, 0, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (stall !== mon_e.stall || fwd_d_rs !== mon_e.drs || fwd_d_rt !== mon_e.drt ||
          fwd_e_rs !== mon_e.ers || fwd_e_rt !== mon_e.ert || md_busy !== mon_e.busy) begin
        bad++;
        $display("FAIL outputs t=%0t got stall=%0b drs=%0d drt=%0d ers=%0d ert=%0d busy=%0b want stall=%0b drs=%0d drt=%0d ers=%0d ert=%0d busy=%0b",
                 $time, stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy,
                 mon_e.stall, mon_e.drs, mon_e.drt, mon_e.ers, mon_e.ert, mon_e.busy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int u1, u2;
    clear_model();
    rst_n = 1'b0;
    d_wr = 1'b0; d_dst = 5'd0; d_tnew = 2'd0; d_rs = 5'd0; d_rt = 5'd0;
    d_rs_use = 2'd3; d_rt_use = 2'd3; d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    step(1'b1, 1'b0, 0, 0, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    nop();
    // load-use: lw $8 then addu using $8 NEXT, held while stalled
    step(1'b0, 1'b1, 8, 2, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 10, 1, 8, 1, 9, 1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    // branch-use: addu $9 then beq using $9 NOW
    step(1'b0, 1'b1, 9, 1, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 0, 0, 9, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    // register 0 writer never hazards
    step(1'b0, 1'b1, 0, 2, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    // priority: E and M both write $5, then W-only
    step(1'b0, 1'b1, 5, 0, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5, 0, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 5, 0, 5, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1 == 1'b0, 1'b1, 5, 0, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    step(1'b0, 1'b0, 0, 0, 5, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    // divide start with mflo waiting in D
    step(1'b0, 1'b0, 0, 0, 0, 3, 0, 3, 1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1, 2, 1, 0, 3, 0, 3, 1'b1, 1'b0, 1'b0);
    // multiply start, then load-use stall interrupted by reset
    step(1'b0, 1'b0, 0, 0, 0, 3, 0, 3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8, 2, 0, 3, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10, 1, 8, 1, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10, 1, 8, 1, 0, 3, 1'b0, 1'b0, 1'b0);
    nop();
    // randomized traffic over a small register window to provoke hits
    for (int i = 0; i < 400; i++) begin
      u1 = int'($urandom_range(0, 2));
      u2 = int'($urandom_range(0, 2));
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 7)), (u1 == 2) ? 3 : u1,
           int'($urandom_range(0, 7)), (u2 == 2) ? 3 : u2,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
